// File: rtl/risc_control_unit.sv
// risc_control_unit: hardwired Moore sequencer driving single-bus RISC datapath strobes
module risc_control_unit #(
    parameter int NUM_GPR      = 16,
    parameter int ALU_OP_W     = 4,
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [31:0]         ir,
    input  logic                mem_ready,
    output logic [NUM_GPR-1:0]  gpr_in,
    output logic [NUM_GPR-1:0]  gpr_out,
    output logic                pc_out,
    output logic                pc_in,
    output logic                inc_pc,
    output logic                ir_in,
    output logic                y_in,
    output logic                z_in,
    output logic                z_low_out,
    output logic                z_high_out,
    output logic                hi_in,
    output logic                lo_in,
    output logic                mar_in,
    output logic                mdr_in,
    output logic                mdr_out,
    output logic                read,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                instr_done,
    output logic                illegal_op,
    output logic                halted,
    output logic                mem_fault
);
    localparam int CW = $clog2(MEM_WAIT_MAX + 1);
    localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(2);

    typedef enum logic [3:0] {IDLE, T0, T1, T1W, T2, T3, T4, T5, T6, HALT} state_t;
    typedef enum logic [2:0] {K_R, K_MD, K_NN, K_NOP, K_HALT, K_ILL} kind_t;

    state_t              state, state_nx;
    kind_t               kind;
    logic [ALU_OP_W-1:0] op;
    logic [CW-1:0]       wait_cnt, wait_cnt_nx;
    logic                fault_set;
    logic [NUM_GPR-1:0]  oh_ra, oh_rb, oh_rc;
    logic                unused_bits;

    assign oh_ra       = NUM_GPR'(1) << ir[26:23];
    assign oh_rb       = NUM_GPR'(1) << ir[22:19];
    assign oh_rc       = NUM_GPR'(1) << ir[18:15];
    assign unused_bits = ^ir[14:0];

    // state, fetch-wait counter and sticky fault flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            mem_fault <= 1'b0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_cnt_nx;
            if (fault_set) mem_fault <= 1'b1;
        end
    end

    // opcode class and ALU operation selected by the instruction
    always_comb begin
        kind = K_ILL;
        op   = '0;
        case (ir[31:27])
            5'b00011: begin kind = K_R;    op = ALU_OP_W'(2);  end
            5'b00100: begin kind = K_R;    op = ALU_OP_W'(3);  end
            5'b00101: begin kind = K_R;    op = ALU_OP_W'(4);  end
            5'b00110: begin kind = K_R;    op = ALU_OP_W'(5);  end
            5'b00111: begin kind = K_R;    op = ALU_OP_W'(6);  end
            5'b01000: begin kind = K_R;    op = ALU_OP_W'(7);  end
            5'b01001: begin kind = K_R;    op = ALU_OP_W'(0);  end
            5'b01010: begin kind = K_R;    op = ALU_OP_W'(1);  end
            5'b01110: begin kind = K_MD;   op = ALU_OP_W'(8);  end
            5'b01111: begin kind = K_MD;   op = ALU_OP_W'(9);  end
            5'b10000: begin kind = K_NN;   op = ALU_OP_W'(10); end
            5'b10001: begin kind = K_NN;   op = ALU_OP_W'(11); end
            5'b11010: kind = K_NOP;
            5'b11011: kind = K_HALT;
            default:  kind = K_ILL;
        endcase
    end

    // next state and Moore strobes for the current step
    always_comb begin
        state_nx    = state;
        wait_cnt_nx = wait_cnt;
        fault_set   = 1'b0;
        gpr_in      = '0;
        gpr_out     = '0;
        pc_out      = 1'b0;
        pc_in       = 1'b0;
        inc_pc      = 1'b0;
        ir_in       = 1'b0;
        y_in        = 1'b0;
        z_in        = 1'b0;
        z_low_out   = 1'b0;
        z_high_out  = 1'b0;
        hi_in       = 1'b0;
        lo_in       = 1'b0;
        mar_in      = 1'b0;
        mdr_in      = 1'b0;
        mdr_out     = 1'b0;
        read        = 1'b0;
        alu_op      = '0;
        instr_done  = 1'b0;
        illegal_op  = 1'b0;
        halted      = 1'b0;
        case (state)
            IDLE: state_nx = T0;
            T0: begin
                pc_out   = 1'b1;
                mar_in   = 1'b1;
                inc_pc   = 1'b1;
                z_in     = 1'b1;
                alu_op   = ALU_ADD;
                state_nx = T1;
            end
            T1: begin
                z_low_out = 1'b1;
                pc_in     = 1'b1;
                read      = 1'b1;
                mdr_in    = 1'b1;
                if (mem_ready) state_nx = T2;
                else begin
                    state_nx    = T1W;
                    wait_cnt_nx = CW'(1);
                end
            end
            T1W: begin
                read   = 1'b1;
                mdr_in = 1'b1;
                if (mem_ready) state_nx = T2;
                else if (wait_cnt == CW'(MEM_WAIT_MAX)) begin
                    fault_set = 1'b1;
                    state_nx  = HALT;
                end else wait_cnt_nx = wait_cnt + CW'(1);
            end
            T2: begin
                mdr_out  = 1'b1;
                ir_in    = 1'b1;
                state_nx = T3;
            end
            T3: begin
                if (kind == K_R || kind == K_MD) begin
                    gpr_out  = (kind == K_MD) ? oh_ra : oh_rb;
                    y_in     = 1'b1;
                    state_nx = T4;
                end else if (kind == K_NN) begin
                    gpr_out  = oh_rb;
                    alu_op   = op;
                    z_in     = 1'b1;
                    state_nx = T4;
                end else begin
                    instr_done = 1'b1;
                    illegal_op = (kind == K_ILL);
                    state_nx   = (kind == K_HALT) ? HALT : T0;
                end
            end
            T4: begin
                if (kind == K_NN) begin
                    z_low_out  = 1'b1;
                    gpr_in     = oh_ra;
                    instr_done = 1'b1;
                    state_nx   = T0;
                end else begin
                    gpr_out  = (kind == K_MD) ? oh_rb : oh_rc;
                    alu_op   = op;
                    z_in     = 1'b1;
                    state_nx = T5;
                end
            end
            T5: begin
                z_low_out = 1'b1;
                if (kind == K_MD) begin
                    lo_in    = 1'b1;
                    state_nx = T6;
                end else begin
                    gpr_in     = oh_ra;
                    instr_done = 1'b1;
                    state_nx   = T0;
                end
            end
            T6: begin
                z_high_out = 1'b1;
                hi_in      = 1'b1;
                instr_done = 1'b1;
                state_nx   = T0;
            end
            HALT:    halted = 1'b1;
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_risc_control_unit.sv
// tb_risc_control_unit: table-driven and randomized checks of the control sequencer
module tb_risc_control_unit;
    typedef struct packed {
        logic [15:0] gin;
        logic [15:0] gout;
        logic [3:0]  alu;
        logic [17:0] s;
    } ctl_t;

    typedef struct {
        string       nm;
        logic [31:0] ir;
        int          waits;
        int          n;
        ctl_t        e [4];
    } vec_t;

    localparam logic [17:0] PCO = 18'd1,    PCI = 18'd2,    INC = 18'd4,     IRI = 18'd8;
    localparam logic [17:0] YIN = 18'd16,   ZIN = 18'd32,   ZLO = 18'd64,    ZHO = 18'd128;
    localparam logic [17:0] HIN = 18'd256,  LOI = 18'd512,  MAR = 18'd1024,  MDI = 18'd2048;
    localparam logic [17:0] MDO = 18'd4096, RD  = 18'd8192, DN  = 18'd16384, ILL = 18'd32768;
    localparam logic [17:0] HLT = 18'd65536, FLT = 18'd131072;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [31:0] ir = '0;
    logic        mem_ready = 1'b0;
    logic [15:0] gpr_in, gpr_out;
    logic        pc_out, pc_in, inc_pc, ir_in, y_in, z_in, z_low_out, z_high_out;
    logic        hi_in, lo_in, mar_in, mdr_in, mdr_out, read;
    logic [3:0]  alu_op;
    logic        instr_done, illegal_op, halted, mem_fault;
    ctl_t        act;
    int          errors = 0;
    int          checks = 0;
    ctl_t        exp_q[$];
    vec_t        tbl[7];

    risc_control_unit dut (
        .clk(clk), .reset_n(reset_n), .ir(ir), .mem_ready(mem_ready),
        .gpr_in(gpr_in), .gpr_out(gpr_out), .pc_out(pc_out), .pc_in(pc_in),
        .inc_pc(inc_pc), .ir_in(ir_in), .y_in(y_in), .z_in(z_in),
        .z_low_out(z_low_out), .z_high_out(z_high_out), .hi_in(hi_in), .lo_in(lo_in),
        .mar_in(mar_in), .mdr_in(mdr_in), .mdr_out(mdr_out), .read(read),
        .alu_op(alu_op), .instr_done(instr_done), .illegal_op(illegal_op),
        .halted(halted), .mem_fault(mem_fault)
    );

    assign act = {gpr_in, gpr_out, alu_op,
                  {mem_fault, halted, illegal_op, instr_done, read, mdr_out, mdr_in, mar_in,
                   lo_in, hi_in, z_high_out, z_low_out, z_in, y_in, ir_in, inc_pc, pc_in, pc_out}};

    always #5 clk = ~clk;

    // bus exclusivity and no register both driving and loading, every cycle out of reset
    always @(negedge clk) begin
        if (reset_n) begin
            checks++;
            if (int'(pc_out) + int'(z_low_out) + int'(z_high_out) + int'(mdr_out) + $countones(gpr_out) > 1
                || (gpr_in & gpr_out) != 0) begin
                errors++;
                $display("FAIL bus_excl: drivers pc=%b zl=%b zh=%b mdr=%b gout=%h gin=%h, required at most one driver",
                         pc_out, z_low_out, z_high_out, mdr_out, gpr_out, gpr_in);
            end
        end
    end

    function automatic ctl_t c(input logic [15:0] gi, input logic [15:0] go, input logic [3:0] a,
                               input logic [17:0] s);
        return {gi, go, a, s};
    endfunction

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic cmp(input ctl_t e, input string nm);
        #1;
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL %s: got gin=%h gout=%h alu=%0d s=%h, required gin=%h gout=%h alu=%0d s=%h",
                     nm, act.gin, act.gout, act.alu, act.s, e.gin, e.gout, e.alu, e.s);
        end
    endtask

    task automatic do_reset;
        reset_n = 1'b0;
        cmp(c(0, 0, 0, 0), "reset_async");
        tick();
        reset_n = 1'b1;
        cmp(c(0, 0, 0, 0), "idle");
        tick();
    endtask

    task automatic push_fetch(input int waits);
        exp_q.delete();
        exp_q.push_back(c(0, 0, 2, PCO | MAR | INC | ZIN));
        exp_q.push_back(c(0, 0, 0, ZLO | PCI | RD | MDI));
        repeat (waits) exp_q.push_back(c(0, 0, 0, RD | MDI));
        exp_q.push_back(c(0, 0, 0, MDO | IRI));
    endtask

    // reference: whole-instruction expectation list from the opcode's class and operand fields
    task automatic model(input logic [31:0] i, input int waits);
        logic [15:0] ra, rb, rc;
        logic [3:0]  alu;
        string       cls;
        ra = 16'd1 << i[26:23];
        rb = 16'd1 << i[22:19];
        rc = 16'd1 << i[18:15];
        alu = 0;
        cls = "ill";
        case (int'(i[31:27]))
            3: begin cls = "r"; alu = 2; end
            4: begin cls = "r"; alu = 3; end
            5: begin cls = "r"; alu = 4; end
            6: begin cls = "r"; alu = 5; end
            7: begin cls = "r"; alu = 6; end
            8: begin cls = "r"; alu = 7; end
            9: begin cls = "r"; alu = 0; end
            10: begin cls = "r"; alu = 1; end
            14: begin cls = "md"; alu = 8; end
            15: begin cls = "md"; alu = 9; end
            16: begin cls = "nn"; alu = 10; end
            17: begin cls = "nn"; alu = 11; end
            26: cls = "nop";
            27: cls = "halt";
            default: cls = "ill";
        endcase
        push_fetch(waits);
        if (cls == "r") begin
            exp_q.push_back(c(0, rb, 0, YIN));
            exp_q.push_back(c(0, rc, alu, ZIN));
            exp_q.push_back(c(ra, 0, 0, ZLO | DN));
        end else if (cls == "md") begin
            exp_q.push_back(c(0, ra, 0, YIN));
            exp_q.push_back(c(0, rb, alu, ZIN));
            exp_q.push_back(c(0, 0, 0, ZLO | LOI));
            exp_q.push_back(c(0, 0, 0, ZHO | HIN | DN));
        end else if (cls == "nn") begin
            exp_q.push_back(c(0, rb, alu, ZIN));
            exp_q.push_back(c(ra, 0, 0, ZLO | DN));
        end else exp_q.push_back(c(0, 0, 0, (cls == "ill") ? (ILL | DN) : DN));
    endtask

    task automatic run_q(input string nm, input logic [31:0] i, input int waits);
        foreach (exp_q[k]) begin
            ir = i;
            mem_ready = (k > waits);
            cmp(exp_q[k], $sformatf("%s_c%0d", nm, k));
            tick();
        end
    endtask

    initial begin
        logic [4:0] legal [13];
        logic [4:0] opc;
        logic [31:0] ri;
        int w;
        legal = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd14, 5'd15, 5'd16, 5'd17, 5'd26};
        tbl[0] = '{"and",  32'h4A920000, 0, 3, '{c(0, 16'h0004, 0, YIN), c(0, 16'h0010, 0, ZIN),
                                                 c(16'h0020, 0, 0, ZLO | DN), c(0, 0, 0, 0)}};
        tbl[1] = '{"mul",  32'h71B00000, 0, 4, '{c(0, 16'h0008, 0, YIN), c(0, 16'h0040, 8, ZIN),
                                                 c(0, 0, 0, ZLO | LOI), c(0, 0, 0, ZHO | HIN | DN)}};
        tbl[2] = '{"neg",  32'h80B80000, 0, 2, '{c(0, 16'h0080, 10, ZIN), c(16'h0002, 0, 0, ZLO | DN),
                                                 c(0, 0, 0, 0), c(0, 0, 0, 0)}};
        tbl[3] = '{"ill",  32'hF8000000, 0, 1, '{c(0, 0, 0, ILL | DN), c(0, 0, 0, 0),
                                                 c(0, 0, 0, 0), c(0, 0, 0, 0)}};
        tbl[4] = '{"subw", 32'h20918000, 3, 3, '{c(0, 16'h0004, 0, YIN), c(0, 16'h0008, 3, ZIN),
                                                 c(16'h0002, 0, 0, ZLO | DN), c(0, 0, 0, 0)}};
        tbl[5] = '{"nop",  32'hD0000000, 0, 1, '{c(0, 0, 0, DN), c(0, 0, 0, 0),
                                                 c(0, 0, 0, 0), c(0, 0, 0, 0)}};
        tbl[6] = '{"notw", 32'h8F800000, 1, 2, '{c(0, 16'h0001, 11, ZIN), c(16'h8000, 0, 0, ZLO | DN),
                                                 c(0, 0, 0, 0), c(0, 0, 0, 0)}};

        tick();
        do_reset();

        foreach (tbl[v]) begin
            push_fetch(tbl[v].waits);
            for (int e = 0; e < tbl[v].n; e++) exp_q.push_back(tbl[v].e[e]);
            run_q(tbl[v].nm, tbl[v].ir, tbl[v].waits);
        end

        for (int r = 0; r < 40; r++) begin
            opc = legal[$urandom_range(0, 12)];
            if ($urandom_range(0, 3) == 0) begin
                opc = 5'($urandom_range(0, 31));
                if (opc == 5'd27) opc = 5'd0;
            end
            ri = {opc, 27'($urandom)};
            w = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 14) : 0;
            model(ri, w);
            run_q($sformatf("rnd%0d", r), ri, w);
        end

        model(32'h1A920000, 0);
        for (int k = 0; k <= 4; k++) begin
            ir = 32'h1A920000;
            mem_ready = 1'b1;
            cmp(exp_q[k], $sformatf("addrst_c%0d", k));
            if (k < 4) tick();
        end
        do_reset();
        model(32'hD0000000, 0);
        run_q("post_rst_nop", 32'hD0000000, 0);

        model(32'hD8000000, 0);
        run_q("halt", 32'hD8000000, 0);
        for (int k = 0; k < 3; k++) begin
            mem_ready = k[0];
            ir = 32'h4A920000;
            cmp(c(0, 0, 0, HLT), $sformatf("halt_hold%0d", k));
            tick();
        end

        do_reset();
        push_fetch(15);
        exp_q.pop_back();
        foreach (exp_q[k]) begin
            mem_ready = 1'b0;
            cmp(exp_q[k], $sformatf("fault_c%0d", k));
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            mem_ready = 1'b1;
            cmp(c(0, 0, 0, HLT | FLT), $sformatf("fault_halt%0d", k));
            tick();
        end
        do_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/risc_control_unit.md
Name: risc_control_unit

Overview:
- Hardwired Moore-style control sequencer for the single-bus RISC datapath.
- Each cycle it drives the bus-out, register-in, ALU-op and memory-read strobes.
- It runs the instruction fetch (T0–T2), then the execute steps for register-format ALU instructions, mul/div, neg/not, nop and halt.
- It replaces the hand-timed strobes a bench otherwise applies to the datapath. It connects port-for-port to the datapath control inputs.

Parameters:
- NUM_GPR, 16, number of general registers; width of the gpr_in/gpr_out one-hot vectors.
- ALU_OP_W, 4, alu_op width.
- MEM_WAIT_MAX, 15, maximum number of fetch wait cycles before a memory fault.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ir  in  32  instruction register contents from the datapath. Fields: opcode [31:27], ra [26:23], rb [22:19], rc [18:15].
- mem_ready  in  1  memory data valid; sampled in fetch-read states.
- gpr_in  out  NUM_GPR  one-hot register load enables.
- gpr_out  out  NUM_GPR  one-hot register bus drives.
- pc_out, pc_in, inc_pc, ir_in, y_in, z_in, z_low_out, z_high_out, hi_in, lo_in, mar_in, mdr_in, mdr_out, read  out  1 each  datapath strobes.
- alu_op  out  ALU_OP_W  ALU operation: And=0, Or=1, Add=2, Sub=3, Shr=4, Shl=5, Ror=6, Rol=7, Mul=8, Div=9, Neg=10, Not=11.
- instr_done  out  1  one-cycle pulse in the final step of each instruction.
- illegal_op  out  1  one-cycle pulse in T3 for an undecoded opcode.
- halted  out  1  high while in HALT.
- mem_fault  out  1  sticky; set on fetch timeout; cleared only by reset.

Behaviour:
- Outputs are a combinational function of the registered state and of ir. The datapath captures them on the next rising edge.
- Any output not listed for a state is 0. alu_op defaults to 0 (And).
- Reset (asynchronous, any time, including mid-instruction or mid-wait):
  - state goes to IDLE and the wait counter clears;
  - mem_fault and all outputs are 0.
- IDLE: all outputs 0. Next: T0.
- T0: pc_out, mar_in, inc_pc, z_in, alu_op=Add. Next: T1.
- T1: z_low_out, pc_in, read, mdr_in.
  - mem_ready=1: next T2.
  - Otherwise: next T1W, and the wait counter loads 1.
- T1W: read, mdr_in only.
  - mem_ready=1: next T2.
  - Counter = MEM_WAIT_MAX with mem_ready=0: set mem_fault, next HALT.
  - Otherwise: counter increments.
- T2: mdr_out, ir_in. Next: T3. ir is valid from T3 onward.
- Opcode decode, bits [31:27]:
  - add 00011, sub 00100, shr 00101, shl 00110, ror 00111, rol 01000, and 01001, or 01010 (R-type);
  - mul 01110, div 01111;
  - neg 10000, not 10001;
  - nop 11010, halt 11011;
  - all others are illegal.
- R-type: ra ← rb op rc.
  - T3: gpr_out=onehot(rb), y_in.
  - T4: gpr_out=onehot(rc), alu_op=op, z_in.
  - T5: z_low_out, gpr_in=onehot(ra), instr_done. Next: T0.
- mul/div: operands ra, rb.
  - T3: gpr_out=onehot(ra), y_in.
  - T4: gpr_out=onehot(rb), alu_op=Mul/Div, z_in.
  - T5: z_low_out, lo_in.
  - T6: z_high_out, hi_in, instr_done. Next: T0.
- neg/not: ra ← op rb.
  - T3: gpr_out=onehot(rb), alu_op=Neg/Not, z_in.
  - T4: z_low_out, gpr_in=onehot(ra), instr_done. Next: T0.
- nop: T3 asserts instr_done only. Next: T0.
- Illegal opcode: T3 asserts illegal_op and instr_done, and the instruction is treated as nop. Next: T0.
- halt: T3 asserts instr_done. Next: HALT.
- HALT: halted=1, all strobes 0. HALT is terminal until reset.
- Bus exclusivity: at most one bus driver is asserted per cycle (pc_out, z_low_out, z_high_out, mdr_out, any gpr_out bit). This is a verification assertion.
- gpr_in and gpr_out are never both non-zero for the same register in the same cycle.
- Cycle counts after the T0 entry cycle: R-type 6, mul/div 7, neg/not 5, nop/illegal 4. Each T1W cycle adds 1.

Test Plan:
- Reset then mem_ready=1, ir=0x4A920000 (and R5,R2,R4) → required sequence:
  - IDLE, then T0 asserts pc_out, mar_in, inc_pc, z_in, alu_op=2;
  - T3: gpr_out=0x0004, y_in;
  - T4: gpr_out=0x0010, alu_op=0, z_in;
  - T5: gpr_in=0x0020, z_low_out, instr_done;
  - then T0.
- ir=0x71B00000 (mul R3,R6):
  - T3: gpr_out=0x0008, y_in;
  - T4: gpr_out=0x0040, alu_op=8, z_in;
  - T5: z_low_out, lo_in;
  - T6: z_high_out, hi_in, instr_done.
- ir=0x80B80000 (neg R1,R7):
  - T3: gpr_out=0x0080, alu_op=10, z_in;
  - T4: z_low_out, gpr_in=0x0002, instr_done.
- mem_ready held 0 for 3 cycles in fetch → 3 T1W cycles with read=mdr_in=1 and pc_in=0, then T2 on mem_ready=1. With mem_ready held 0 for 16 cycles: mem_fault=1, halted=1.
- ir=0xF8000000 → illegal_op and instr_done pulse once in T3, then T0. ir=0xD8000000 → halted=1 and all strobes 0 thereafter.
- reset_n pulsed low during T4 of an add → outputs 0 immediately (asynchronous), then IDLE→T0 after release; mem_fault cleared.
